// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler: round-robin burst drain of NUM_CH channel FIFOs
// onto one shared output stream tagged with the channel number.
module fifo_burst_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int CW        = 5,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    input  logic [NUM_CH-1:0]         in_enable,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*CW-1:0]      in_count,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_enable,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int RW  = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [CW-1:0]  THRESH  = CW'(MAX_BURST);
    localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
    localparam logic [RW-1:0]  ONE     = RW'(1);

    logic [0:0]        state;
    logic [CHW-1:0]    last_grant;
    logic [RW-1:0]     remaining;
    logic [TW-1:0]     timer [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic              found;
    logic [CHW-1:0]    pick;
    logic [CW-1:0]     cnt_sel;
    logic [RW-1:0]     burst_len;
    logic              grant;
    logic              active;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = (in_count[i*CW +: CW] >= THRESH)
                       || (in_enable[i] && timer[i] == TMAX);
        end
    end

    // Rotate from the channel after last_grant so nobody is starved.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = CHW'(idx);
            end
        end
    end

    // A timeout grant can see a lagging count of 0; still move one word.
    always_comb begin
        cnt_sel = in_count[pick*CW +: CW];
        if (cnt_sel == '0)
            burst_len = ONE;
        else if (cnt_sel >= THRESH)
            burst_len = RW'(MAX_BURST);
        else
            burst_len = RW'(cnt_sel);
    end

    assign grant  = (state == IDLE) && enable && found;
    assign active = (state == BURST) && !reset;
    assign xfer   = in_enable[out_ch] && out_ready;

    always_comb begin
        in_ready   = '0;
        out_data   = '0;
        out_enable = 1'b0;
        if (active) begin
            out_data         = in_data[out_ch*WIDTH +: WIDTH];
            out_enable       = in_enable[out_ch];
            in_ready[out_ch] = out_ready;
        end
    end

    assign out_last = out_enable && (remaining == ONE);
    assign busy     = (state == BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_CH;
            remaining  <= '0;
            out_ch     <= '0;
        end else if (grant) begin
            state      <= BURST;
            last_grant <= pick;
            out_ch     <= pick;
            remaining  <= burst_len;
        end else if (state == BURST && xfer) begin
            remaining <= remaining - ONE;
            if (remaining == ONE)
                state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || !in_enable[i] || (grant && pick == CHW'(i)))
                timer[i] <= '0;
            else if (!(busy && out_ch == CHW'(i)) && timer[i] != TMAX)
                timer[i] <= timer[i] + TW'(1);
        end
    end

endmodule
